// File: rtl/exu_bp_update_q.sv
// exu_bp_update_q: in-order FIFO of resolved-branch predictor updates toward the IFU, with stall and statistics
module exu_bp_update_q #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i0_valid,
  input  logic [30:0]      i0_pc,
  input  logic [1:0]       i0_hist,
  input  logic             i0_misp,
  input  logic             i0_ataken,
  input  logic             i1_valid,
  input  logic [30:0]      i1_pc,
  input  logic [1:0]       i1_hist,
  input  logic             i1_misp,
  input  logic             i1_ataken,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [30:0]      upd_pc,
  output logic [1:0]       upd_hist,
  output logic             upd_misp,
  output logic             upd_ataken,
  output logic             bpq_stall,
  output logic             drop_sticky,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_misp,
  output logic [CNT_W-1:0] cnt_drop
);
  localparam int REC_W = 35;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   count_q, count_d, free;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             stall_q, stall_d, sticky_q, sticky_d;
  logic [CNT_W-1:0] total_q, total_d, misp_q, misp_d, drop_q, drop_d;
  logic             push0, push1, acc0, acc1, drop0, drop1, pop;
  always_comb begin
    push0 = i0_valid & ~flush;
    push1 = i1_valid & ~flush;
    free = (PTR_W+1)'(DEPTH) - count_q;
    acc0 = push0 & (free != '0);
    acc1 = push1 & (push0 ? free >= (PTR_W+1)'(2) : free != '0);
    drop0 = push0 & ~acc0;
    drop1 = push1 & ~acc1;
    pop = (count_q != '0) & upd_ready;
    mem_d = mem_q;
    if (acc0) mem_d[wr_ptr_q] = {i0_pc, i0_hist, i0_misp, i0_ataken};
    if (acc1) mem_d[acc0 ? wr_ptr_q + 1'b1 : wr_ptr_q] = {i1_pc, i1_hist, i1_misp, i1_ataken};
    wr_ptr_d = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(acc0) + (PTR_W+1)'(acc1) - (PTR_W+1)'(pop);
    stall_d = count_d >= (PTR_W+1)'(DEPTH - 2);
    sticky_d = sticky_q | drop0 | drop1;
    total_d = total_q + CNT_W'(acc0) + CNT_W'(acc1);
    misp_d = misp_q + CNT_W'(acc0 & i0_misp) + CNT_W'(acc1 & i1_misp);
    drop_d = drop_q + CNT_W'(drop0) + CNT_W'(drop1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      stall_q  <= 1'b0;
      sticky_q <= 1'b0;
      total_q  <= '0;
      misp_q   <= '0;
      drop_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      stall_q  <= stall_d;
      sticky_q <= sticky_d;
      total_q  <= total_d;
      misp_q   <= misp_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign upd_valid = count_q != '0;
  assign {upd_pc, upd_hist, upd_misp, upd_ataken} = mem_q[rd_ptr_q];
  assign bpq_stall = stall_q;
  assign drop_sticky = sticky_q;
  assign cnt_total = total_q;
  assign cnt_misp = misp_q;
  assign cnt_drop = drop_q;
endmodule

// File: tb/tb_exu_bp_update_q.sv
// tb_exu_bp_update_q: scoreboard bench comparing the update queue against a queue-based reference model
module tb_exu_bp_update_q;
  localparam int DEPTH = 4;
  localparam int CNT_W = 32;
  typedef struct packed {
    logic [30:0] pc;
    logic [1:0]  hist;
    logic        misp;
    logic        ataken;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, upd_ready = 1'b0;
  logic i0_valid = 1'b0, i0_misp = 1'b0, i0_ataken = 1'b0;
  logic i1_valid = 1'b0, i1_misp = 1'b0, i1_ataken = 1'b0;
  logic [30:0] i0_pc = '0, i1_pc = '0, upd_pc;
  logic [1:0] i0_hist = '0, i1_hist = '0, upd_hist;
  logic upd_valid, upd_misp, upd_ataken, bpq_stall, drop_sticky;
  logic [CNT_W-1:0] cnt_total, cnt_misp, cnt_drop;
  rec_t sb[$];
  int exp_start = 0;
  logic [CNT_W-1:0] m_total = '0, m_misp = '0, m_drop = '0;
  logic [CNT_W-1:0] e_total = '0, e_misp = '0, e_drop = '0;
  logic m_sticky = 1'b0, e_sticky = 1'b0;
  bit chk = 1'b0;
  int errs = 0, checks = 0;
  exu_bp_update_q #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i0_valid(i0_valid), .i0_pc(i0_pc), .i0_hist(i0_hist), .i0_misp(i0_misp), .i0_ataken(i0_ataken),
    .i1_valid(i1_valid), .i1_pc(i1_pc), .i1_hist(i1_hist), .i1_misp(i1_misp), .i1_ataken(i1_ataken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_misp(upd_misp), .upd_ataken(upd_ataken), .bpq_stall(bpq_stall), .drop_sticky(drop_sticky),
    .cnt_total(cnt_total), .cnt_misp(cnt_misp), .cnt_drop(cnt_drop)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      check("upd_valid", 64'(upd_valid), 64'(exp_start != 0));
      check("bpq_stall", 64'(bpq_stall), 64'(exp_start >= DEPTH - 2));
      check("drop_sticky", 64'(drop_sticky), 64'(e_sticky));
      check("cnt_total", 64'(cnt_total), 64'(e_total));
      check("cnt_misp", 64'(cnt_misp), 64'(e_misp));
      check("cnt_drop", 64'(cnt_drop), 64'(e_drop));
      if (upd_valid) begin
        if (sb.size() == 0) check("head_present", 64'(0), 64'(1));
        else begin
          check("upd_record", 64'({upd_pc, upd_hist, upd_misp, upd_ataken}), 64'(sb[0]));
          if (upd_ready) void'(sb.pop_front());
        end
      end
    end
  end
  function automatic rec_t mk(input logic [30:0] pc, input logic [1:0] h, input logic m, input logic t);
    rec_t r;
    r.pc = pc;
    r.hist = h;
    r.misp = m;
    r.ataken = t;
    return r;
  endfunction
  function automatic rec_t rnd_rec();
    return mk(31'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
  endfunction
  task automatic step(input logic v0, input rec_t r0, input logic v1, input rec_t r1, input logic fl, input logic rdy);
    rec_t cand[$];
    int free;
    i0_valid = v0;
    {i0_pc, i0_hist, i0_misp, i0_ataken} = r0;
    i1_valid = v1;
    {i1_pc, i1_hist, i1_misp, i1_ataken} = r1;
    flush = fl;
    upd_ready = rdy;
    exp_start = sb.size();
    e_total = m_total;
    e_misp = m_misp;
    e_drop = m_drop;
    e_sticky = m_sticky;
    if (!fl && v0) cand.push_back(r0);
    if (!fl && v1) cand.push_back(r1);
    free = DEPTH - exp_start;
    foreach (cand[k]) begin
      if (k < free) begin
        sb.push_back(cand[k]);
        m_total += 1;
        m_misp += CNT_W'(cand[k].misp);
      end else begin
        m_drop += 1;
        m_sticky = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0, rdy);
  endtask
  task automatic do_reset();
    chk = 1'b0;
    rst = 1'b1;
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    flush = 1'b0;
    upd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_total = '0;
    m_misp = '0;
    m_drop = '0;
    m_sticky = 1'b0;
    chk = 1'b1;
  endtask
  initial begin
    @(posedge clk);
    do_reset();
    step(1'b1, mk(31'h100, 2'b10, 1'b1, 1'b1), 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0, 3);
    idle(1'b1, 2);
    step(1'b1, mk(31'h200, 2'b01, 1'b0, 1'b1), 1'b1, mk(31'h204, 2'b11, 1'b0, 1'b0), 1'b0, 1'b0);
    idle(1'b1, 3);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b0, 1'b1);
    idle(1'b1, 5);
    for (int k = 0; k < 3; k++) step(1'b1, rnd_rec(), 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, mk(31'h300, 2'b00, 1'b1, 1'b0), 1'b1, mk(31'h304, 2'b01, 1'b1, 1'b1), 1'b0, 1'b0);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b1, 1'b0);
    idle(1'b1, 5);
    step(1'b1, rnd_rec(), 1'b1, rnd_rec(), 1'b1, 1'b0);
    idle(1'b0, 1);
    for (int k = 0; k < 10; k++) step(1'b1, mk(31'(k + 'h400), 2'(k), 1'(k), 1'(k >> 1)), 1'b0, '0, 1'b0, 1'b1);
    idle(1'b1, 2);
    for (int k = 0; k < 3; k++) step(1'b1, rnd_rec(), 1'b0, '0, 1'b0, 1'b0);
    do_reset();
    idle(1'b0, 2);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step(1'($urandom_range(99) < 60), rnd_rec(), 1'($urandom_range(99) < 50), rnd_rec(),
                1'($urandom_range(99) < 8), 1'($urandom_range(99) < 45));
    end
    idle(1'b1, 6);
    chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/exu_bp_update_q.md
Name: exu_bp_update_q

Overview:
- Sits directly downstream of the two EXU ALU branch-resolution stages (i0, i1).
- Captures each resolved branch's predictor-update record (pc, updated hist, misp, ataken).
- Buffers records in order in a small FIFO and drains them to the IFU BHT/BTB write port over a valid/ready handshake.
- Raises a stall toward the decode freeze logic before it overflows, and keeps wrap-around branch statistics counters.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥4.
- PTR_W, 2: log2(DEPTH).
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset; synchronous, active-high
- flush  input  1  pipeline flush; cancels this cycle's incoming records only
- i0_valid  input  1  i0 resolved-branch record valid
- i0_pc  input  31  i0 branch pc[31:1]
- i0_hist  input  2  i0 new 2-bit history
- i0_misp  input  1  i0 mispredicted
- i0_ataken  input  1  i0 actual taken
- i1_valid, i1_pc, i1_hist, i1_misp, i1_ataken  input  1/31/2/1/1  same fields for i1 (younger)
- upd_valid  output  1  head record valid toward IFU
- upd_ready  input  1  IFU accepts head this cycle
- upd_pc  output  31  head pc[31:1]
- upd_hist  output  2  head history
- upd_misp  output  1  head misp
- upd_ataken  output  1  head ataken
- bpq_stall  output  1  request pipeline freeze
- drop_sticky  output  1  a record was ever dropped since reset
- cnt_total  output  CNT_W  records accepted
- cnt_misp  output  CNT_W  accepted records with misp=1
- cnt_drop  output  CNT_W  records dropped

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - All counters go to 0; drop_sticky=0; upd_valid=0; bpq_stall=0.
  - upd_* data outputs are don't-care while upd_valid=0.
  - Reset overrides every same-cycle push, pop and flush.
  - A mid-drain reset discards all queued records.
- Push qualification: push_k = ik_valid & ~flush. When flush=1, neither record is counted, stored or dropped.
- Ordering: i0 is older than i1. When both push, i0 goes into wr_ptr and i1 into wr_ptr+1. Pointers wrap modulo DEPTH.
- Space check: uses count at the start of the cycle. A same-cycle pop does not free space for a same-cycle push.
  - free = DEPTH-count.
  - Both pushing with free≥2: both accepted.
  - Both pushing with free=1: i0 accepted, i1 dropped.
  - free=0: every push is dropped.
  - A lone i1 push needs free≥1.
- Drop handling: each dropped record increments cnt_drop (+1 or +2 in one cycle) and sets drop_sticky.
- Pop: occurs when upd_valid & upd_ready. rd_ptr advances by 1 with wrap. upd_ready while empty has no effect.
- Count: count_next = count + accepted_pushes − pop. The range is 0..DEPTH.
- Latency: a record accepted at edge N appears on upd_* after edge N (visible in cycle N+1) if the queue was empty. There is no combinational bypass.
- Output hold: upd_valid = (count≠0). upd_* are driven from the registered FIFO head, and stay stable while upd_valid & ~upd_ready.
- Stall: bpq_stall = (count ≥ DEPTH−2), registered from count_next, so it is effective in the cycle after the fill. Two in-flight records then still fit, and the freeze logic guarantees no drop in normal use.
- Statistics counters: update on accepted pushes only.
  - cnt_total increments by 0..2 per cycle.
  - cnt_misp adds the misp bits of the accepted records.
  - All counters wrap modulo 2^CNT_W.
- Empty and full simultaneous events:
  - Push and pop in the same cycle with count=DEPTH: the pop proceeds and the push is dropped.
  - Push into an empty queue while upd_ready=1: stored; pops next cycle at the earliest.

Test Plan:
- Basic path: reset; i0_valid with pc=0x100, hist=2'b10, misp=1, ataken=1; upd_ready=0 → next cycle upd_valid=1 with the same fields, held stable for 3 cycles; then upd_ready=1 → upd_valid=0 the following cycle; cnt_total=1, cnt_misp=1.
- Dual issue order: i0 pc=0x200 and i1 pc=0x204 in the same cycle → drains pc 0x200 then 0x204 on consecutive ready cycles; cnt_total=2.
- Fill and drop (DEPTH=4, upd_ready=0): 2 dual pushes → count=4, bpq_stall=1 after the count reaches 2; a further dual push → cnt_drop=2, drop_sticky=1, FIFO contents unchanged.
- Partial space: count=3, dual push with misp=1 on both → i0 accepted, i1 dropped; cnt_misp +1, cnt_drop +1.
- Flush: i0_valid=i1_valid=1 with flush=1 → no count change, no counter change, drop_sticky unchanged.
- Wrap and reset: 10 single pushes with pop every cycle → pointers wrap and order is preserved; then rst with count=3 → upd_valid=0, all counters 0 on the next cycle.
